// File: rtl/radio_rx_frame_packer.sv
// Packs one length-prefixed radio receive frame at a time into 16-bit SRAM FIFO words.
// Frames that do not fit are consumed and dropped whole; aborted frames are zero-padded.
module radio_rx_frame_packer #(
    parameter int FIFO_WORDS = 2047,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_start,
    input  logic [7:0]        rx_len,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              rx_abort,
    output logic              SRAM_write,
    output logic [15:0]       Data_to_sram,
    input  logic              SRAM_hint,
    input  logic              SRAM_full,
    input  logic [10:0]       SRAM_count,
    output logic              frame_recved_int,
    output logic              busy,
    output logic              frame_err,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_FETCH_HI, S_FETCH_LO, S_WRITE,
        S_WAIT_HINT, S_DONE, S_DROP, S_PAD
    } state_t;

    state_t            state_q, state_d, ret_q, ret_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [8:0]        words_q, words_d;
    logic [15:0]       word_q, word_d;
    logic              pad_q, pad_d;
    logic              abort_pend_q, abort_pend_d;
    logic              err_q, err_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [8:0]  words_total;
    logic [11:0] free_words;
    logic        take, got_byte, last_byte, abort_now, last_word, drop_inc;
    logic [7:0]  in_byte;

    assign words_total = ({1'b0, len_q} + 9'd2) >> 1;
    assign free_words  = 12'(FIFO_WORDS) - {1'b0, SRAM_count};
    assign rx_ready    = ((state_q == S_FETCH_HI || state_q == S_FETCH_LO) && !pad_q)
                       || (state_q == S_DROP && len_q != 8'd0);
    // An abort in the same cycle as a valid byte wins: the byte is not taken.
    assign take        = rx_valid && rx_ready && !rx_abort;
    // Once padding, the fetch states consume implicit zero bytes without the radio.
    assign got_byte    = pad_q || take;
    assign in_byte     = pad_q ? 8'h00 : rx_byte;
    assign last_byte   = ({1'b0, byte_cnt_q} + 9'd1) == {1'b0, len_q};
    assign abort_now   = rx_abort && !pad_q;
    assign last_word   = (words_q + 9'd1) == words_total;

    assign SRAM_write   = (state_q == S_WAIT_HINT);
    assign Data_to_sram = word_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_err    = err_q;
    assign drop_count   = drop_q;

    always_comb begin
        state_d          = state_q;
        ret_d            = ret_q;
        len_d            = len_q;
        byte_cnt_d       = byte_cnt_q;
        words_d          = words_q;
        word_d           = word_q;
        pad_d            = pad_q;
        abort_pend_d     = abort_pend_q;
        err_d            = err_q;
        drop_inc         = 1'b0;
        frame_recved_int = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_start) begin
                    len_d        = rx_len;
                    byte_cnt_d   = 8'd0;
                    words_d      = 9'd0;
                    pad_d        = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (len_q == 8'd0 || free_words < {3'b000, words_total}) begin
                    state_d = S_DROP;
                end else begin
                    word_d  = {len_q, 8'h00};
                    state_d = S_FETCH_LO;
                end
            end
            S_FETCH_HI: begin
                if (abort_now) begin
                    ret_d   = S_FETCH_HI;
                    state_d = S_PAD;
                end else if (got_byte) begin
                    word_d[15:8] = in_byte;
                    byte_cnt_d   = byte_cnt_q + 8'd1;
                    if (last_byte) begin
                        word_d[7:0] = 8'h00;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_FETCH_LO;
                    end
                end
            end
            S_FETCH_LO: begin
                if (abort_now) begin
                    ret_d   = S_FETCH_LO;
                    state_d = S_PAD;
                end else if (got_byte) begin
                    word_d[7:0] = in_byte;
                    byte_cnt_d  = byte_cnt_q + 8'd1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort_now) begin
                    ret_d   = S_WRITE;
                    state_d = S_PAD;
                end else if (!SRAM_full) begin
                    state_d = S_WAIT_HINT;
                end
            end
            S_WAIT_HINT: begin
                // The handshake in flight completes before an abort takes effect.
                if (abort_now) abort_pend_d = 1'b1;
                if (SRAM_hint) begin
                    words_d = words_q + 9'd1;
                    if (abort_now || abort_pend_q) begin
                        ret_d   = last_word ? S_DONE : S_FETCH_HI;
                        state_d = S_PAD;
                    end else begin
                        state_d = last_word ? S_DONE : S_FETCH_HI;
                    end
                end
            end
            S_PAD: begin
                pad_d        = 1'b1;
                abort_pend_d = 1'b0;
                err_d        = 1'b1;
                state_d      = ret_q;
            end
            S_DONE: begin
                frame_recved_int = 1'b1;
                state_d          = S_IDLE;
            end
            S_DROP: begin
                if (rx_abort || len_q == 8'd0) begin
                    drop_inc = 1'b1;
                    state_d  = S_IDLE;
                end else if (take) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    if (last_byte) begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (drop_inc && drop_q != {DROP_W{1'b1}}) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            len_q        <= 8'd0;
            byte_cnt_q   <= 8'd0;
            words_q      <= 9'd0;
            word_q       <= 16'd0;
            pad_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            err_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            words_q      <= words_d;
            word_q       <= word_d;
            pad_q        <= pad_d;
            abort_pend_q <= abort_pend_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_radio_rx_frame_packer.sv
// Scoreboard bench for radio_rx_frame_packer: a reference model turns each frame into
// the expected SRAM word list; a monitor checks every SRAM handshake and interrupt.
module tb_radio_rx_frame_packer;

    localparam int FIFO_WORDS = 2047;
    localparam int DROP_W     = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_start = 1'b0;
    logic [7:0]  rx_len = 8'd0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_abort = 1'b0;
    logic        SRAM_hint = 1'b0;
    logic        SRAM_full = 1'b0;
    logic [10:0] SRAM_count = 11'd0;
    logic        rx_ready, SRAM_write, frame_recved_int, busy, frame_err;
    logic [15:0] Data_to_sram;
    logic [DROP_W-1:0] drop_count;

    radio_rx_frame_packer #(.FIFO_WORDS(FIFO_WORDS), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset_n(reset_n), .rx_start(rx_start), .rx_len(rx_len),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_abort(rx_abort),
        .SRAM_write(SRAM_write), .Data_to_sram(Data_to_sram), .SRAM_hint(SRAM_hint),
        .SRAM_full(SRAM_full), .SRAM_count(SRAM_count), .frame_recved_int(frame_recved_int),
        .busy(busy), .frame_err(frame_err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [16:0] exp_q[$];        // {last_word, data}
    int          irq_due = -1;
    int          exp_drop = 0;
    logic        exp_err = 1'b0;
    logic        hint_hold = 1'b0;
    logic [7:0]  tx_pay [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // SRAM side: answer each write request after 0..5 cycles.
    initial begin
        int dly;
        bit armed;
        dly = 0;
        armed = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                SRAM_hint = 1'b0;
                armed = 0;
            end else if (SRAM_hint) begin
                SRAM_hint = 1'b0;
            end else if (SRAM_write && !hint_hold) begin
                if (!armed) begin
                    dly = $urandom_range(0, 5);
                    armed = 1;
                end
                if (dly == 0) begin
                    SRAM_hint = 1'b1;
                    armed = 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: pops expected words on each handshake and tracks the interrupt slot.
    initial begin
        logic        prev_w;
        logic [15:0] held;
        logic [16:0] e;
        prev_w = 1'b0;
        held = 16'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_w = 1'b0;
                irq_due = -1;
            end else begin
                if (SRAM_write && prev_w) check("data_stable", Data_to_sram, held);
                if (SRAM_write && !prev_w) held = Data_to_sram;
                if (SRAM_write && SRAM_hint) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %0h with no expected word", Data_to_sram);
                    end else begin
                        e = exp_q.pop_front();
                        check("sram_word", Data_to_sram, e[15:0]);
                        if (e[16]) irq_due = cyc + 1;
                    end
                end
                if (frame_recved_int || cyc == irq_due) begin
                    checks++;
                    if (!(frame_recved_int && cyc == irq_due)) begin
                        errors++;
                        $display("FAIL irq_timing: irq=%0b at cycle %0d, expected cycle %0d",
                                 frame_recved_int, cyc, irq_due);
                    end
                    if (cyc == irq_due) irq_due = -1;
                end
                prev_w = SRAM_write;
            end
        end
    end

    // Reference model: stream = len, payload (zeros after abort), zero fill; pair into words.
    function automatic void model_frame(input int len, input int sent);
        logic [7:0] s [0:257];
        int w;
        s[0] = 8'(len);
        for (int i = 1; i < 258; i++) s[i] = (i <= sent && i <= len) ? tx_pay[i-1] : 8'h00;
        w = (len + 2) / 2;
        for (int j = 0; j < w; j++) exp_q.push_back({(j == w - 1), s[2*j], s[2*j+1]});
    endfunction

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b expected 0", busy);
        end
    endtask

    task automatic send_frame(input int len, input int abort_k, input bit stray,
                              input bit full_hold, input bit timing, input bit randfull);
        int w, free, nfeed, idx, guard, held_cyc;
        bit ok;
        wait_idle();
        w = (len + 2) / 2;
        free = FIFO_WORDS - int'(SRAM_count);
        nfeed = (abort_k >= 0) ? abort_k : len;
        if (len == 0 || free < w) begin
            if (exp_drop < 255) exp_drop++;
            if (len == 0) nfeed = 0;
        end else begin
            model_frame(len, nfeed);
            if (abort_k >= 0) exp_err = 1'b1;
        end
        if (full_hold) SRAM_full = 1'b1;
        @(negedge clk);
        rx_start = 1'b1;
        rx_len = 8'(len);
        @(negedge clk);
        rx_start = 1'b0;
        if (timing) begin
            check("ready_low_in_check", rx_ready, 1'b0);
            check("busy_in_check", busy, 1'b1);
            @(negedge clk);
            check("ready_high_t2", rx_ready, 1'b1);
        end
        idx = 0;
        guard = 0;
        held_cyc = 0;
        while (idx < nfeed && guard < 4000) begin
            rx_valid = ($urandom_range(0, 3) != 0);
            rx_byte = tx_pay[idx];
            if (stray && $urandom_range(0, 7) == 0) begin
                rx_start = 1'b1;
                rx_len = 8'($urandom);
            end else begin
                rx_start = 1'b0;
            end
            if (full_hold && idx >= 1) begin
                if (held_cyc < 10) begin
                    check("no_write_while_full", SRAM_write, 1'b0);
                    held_cyc++;
                end else begin
                    SRAM_full = 1'b0;
                end
            end else if (randfull) begin
                SRAM_full = ($urandom_range(0, 3) == 0);
            end
            ok = rx_valid && rx_ready;
            @(negedge clk);
            if (ok) idx++;
            guard++;
        end
        rx_valid = 1'b0;
        rx_start = 1'b0;
        SRAM_full = 1'b0;
        if (idx < nfeed) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: accepted %0d bytes expected %0d", idx, nfeed);
        end
        if (abort_k >= 0) begin
            rx_abort = 1'b1;
            rx_valid = 1'b1;
            rx_byte = 8'hEE;
            @(negedge clk);
            rx_abort = 1'b0;
            rx_valid = 1'b0;
        end
        wait_idle();
        @(negedge clk);
        check("drop_count", drop_count, exp_drop);
        check("frame_err", frame_err, exp_err);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sram_write"}, SRAM_write, 1'b0);
        check({tag, "_data"}, Data_to_sram, 16'h0000);
        check({tag, "_rx_ready"}, rx_ready, 1'b0);
        check({tag, "_irq"}, frame_recved_int, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_drop_count"}, drop_count, 8'd0);
    endtask

    initial begin
        int len, ab, r, g;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        tx_pay[0] = 8'hA1; tx_pay[1] = 8'hA2; tx_pay[2] = 8'hA3;
        send_frame(3, -1, 0, 0, 1, 0);

        tx_pay[0] = 8'h11; tx_pay[1] = 8'h22; tx_pay[2] = 8'h33; tx_pay[3] = 8'h44;
        send_frame(4, -1, 0, 0, 0, 0);

        SRAM_count = 11'd2046;
        send_frame(2, -1, 0, 0, 0, 0);
        SRAM_count = 11'd0;

        for (int i = 0; i < 256; i++) tx_pay[i] = 8'($urandom);
        send_frame(20, -1, 1, 1, 0, 0);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 256; i++) tx_pay[i] = 8'($urandom);
            len = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 255);
            ab = (len >= 2 && $urandom_range(0, 6) == 0) ? $urandom_range(1, len - 1) : -1;
            r = $urandom_range(0, 3);
            if (r == 0)      SRAM_count = 11'(FIFO_WORDS - (len + 2) / 2);
            else if (r == 1) SRAM_count = 11'(FIFO_WORDS - (len + 2) / 2 + 1);
            else             SRAM_count = 11'($urandom_range(0, 1500));
            send_frame(len, ab, $urandom_range(0, 1), 0, 0, 1);
        end

        SRAM_count = 11'd2046;
        for (int n = 0; n < 300; n++) send_frame(2, -1, 0, 0, 0, 0);
        SRAM_count = 11'd0;

        tx_pay[0] = 8'hB0; tx_pay[1] = 8'hB1;
        send_frame(5, 2, 0, 0, 0, 0);

        // Asynchronous reset while a write request is held open.
        wait_idle();
        hint_hold = 1'b1;
        @(negedge clk);
        rx_start = 1'b1;
        rx_len = 8'd5;
        @(negedge clk);
        rx_start = 1'b0;
        rx_valid = 1'b1;
        rx_byte = 8'hC3;
        g = 0;
        while (!SRAM_write && g < 50) begin
            @(negedge clk);
            g++;
        end
        rx_valid = 1'b0;
        check("write_before_reset", SRAM_write, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        exp_drop = 0;
        exp_err = 1'b0;
        hint_hold = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tx_pay[0] = 8'hB7;
        send_frame(1, -1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/radio_rx_frame_packer.md
# radio_rx_frame_packer

Receive-direction frame packer between the Si4463 radio receive byte stream and the shared receive SRAM FIFO. It accepts one length-prefixed frame at a time and packs it into 16-bit SRAM words, using the layout that the CPU-side SPI controller unpacks when the CPU issues its receive command (0x77). When the last word of a frame is committed, it pulses `frame_recved_int` toward the SPI controller's interrupt logic. Frames that cannot fit in the FIFO are dropped whole, so the FIFO always holds complete frames.

## Interface
Parameters:
- `FIFO_WORDS`, default 2047: usable SRAM FIFO capacity in 16-bit words.
- `DROP_W`, default 8: width of the saturating drop counter.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_start` in 1: one-cycle pulse marking frame start; `rx_len` is valid in the same cycle.
- `rx_len` in 8: payload byte count, 1..255.
- `rx_byte` in 8: payload byte.
- `rx_valid` in 1: `rx_byte` is valid.
- `rx_ready` out 1: the packer accepts `rx_byte` in this cycle.
- `rx_abort` in 1: the radio abandons the current frame.
- `SRAM_write` out 1: write request to the SRAM FIFO.
- `Data_to_sram` out 16: write data.
- `SRAM_hint` in 1: the SRAM has taken the current request.
- `SRAM_full` in 1: the FIFO is full.
- `SRAM_count` in 11: words currently held in the FIFO.
- `frame_recved_int` out 1: one-cycle pulse when a frame is complete in SRAM.
- `busy` out 1: a frame is in progress (any state other than IDLE).
- `frame_err` out 1: sticky flag, set when a frame was padded after an abort; cleared only by reset.
- `drop_count` out DROP_W: saturating count of dropped frames.

## Operation
- SRAM word layout per frame:
  - word0 = {len, b0}
  - then {b1, b2}, {b3, b4}, …
  - if len is even, the last word is {b(len-1), 8'h00}.
  - Word count W = (len+2)>>1, computed 9 bits wide. Examples: len=1 gives W=1; len=2 gives W=2; len=255 gives W=128.
- States:
  - IDLE: wait for `rx_start`. On `rx_start`, latch len, set byte counter to 0, go to CHECK.
  - CHECK (one cycle): free = FIFO_WORDS − `SRAM_count`, computed 12 bits wide.
    - len==0 or free<W: go to DROP.
    - otherwise: go to FETCH_HI.
  - FETCH_HI / FETCH_LO: `rx_ready`=1 and take one byte per state into the high or low byte of the word register.
    - word0: the high byte is preloaded with len, so only FETCH_LO runs.
    - After the last byte, if the low byte is still empty, fill it with 00 and go to WRITE.
  - WRITE: when `SRAM_full`=0, assert `SRAM_write`, go to WAIT_HINT.
  - WAIT_HINT: hold `SRAM_write` and `Data_to_sram` until `SRAM_hint`=1; deassert in the next cycle.
    - If words written == W: go to DONE.
    - Otherwise: go to FETCH_HI.
  - DONE: pulse `frame_recved_int` for exactly one cycle, then go to IDLE.
  - DROP: `rx_ready`=1. Count and discard len bytes; len==0 discards nothing. Increment `drop_count`, saturating at all-ones. Go to IDLE with no SRAM access and no interrupt.
  - PAD: entered when `rx_abort` arrives in FETCH_HI, FETCH_LO, WRITE or WAIT_HINT. Substitute 00 for every remaining byte, write the remaining words normally, set `frame_err`, then go to DONE (the interrupt still fires).
    - An abort during WAIT_HINT finishes the current handshake first.
    - `rx_abort` in DROP ends the drop immediately and still counts it.
    - `rx_abort` in IDLE or CHECK is ignored.
- `rx_start` while `busy`=1 is ignored and not counted.
- Simultaneous `rx_valid` and `rx_abort`: the abort wins and the byte is not taken.

## Timing
- Reset values: `SRAM_write`=0, `Data_to_sram`=0, `rx_ready`=0, `frame_recved_int`=0, `busy`=0, `frame_err`=0, `drop_count`=0, state=IDLE.
- Reset mid-frame drops the frame immediately. The SRAM FIFO shares `reset_n` and is flushed by it.
- Relative to an `rx_start` sampled at edge T:
  - CHECK is at T+1.
  - `rx_ready` first goes high at T+2.
- A byte is accepted at any edge where `rx_valid`&&`rx_ready`. `rx_ready` is low in WRITE, WAIT_HINT, DONE and PAD.
- `SRAM_write` rises no earlier than one cycle after the word's last byte is accepted. `Data_to_sram` is stable from the rise of `SRAM_write` through the `SRAM_hint` cycle.
- After a `SRAM_hint` at edge H, `SRAM_write` is 0 at H+1. There is at least one low cycle between writes.
- For a last-word `SRAM_hint` at edge H, `frame_recved_int`=1 during H+1 only, and IDLE is reached at H+2. The earliest new `rx_start` is sampled at H+2.
- `SRAM_full`=1 in WRITE stalls indefinitely with `SRAM_write`=0.
- Throughput is at most one word per 3 cycles.

## Test plan
- Frame with len=3, bytes A1 A2 A3, free space → writes 0x03A1 then 0xA2A3; one `frame_recved_int` pulse; `drop_count`=0.
- len=4, bytes 11 22 33 44 → writes 0x0411, 0x2233, 0x4400; pulse fires exactly one cycle after the third `SRAM_hint`.
- `SRAM_count`=2046 with `FIFO_WORDS`=2047 and len=2 (W=2) → 2 bytes consumed with `rx_ready` high; no `SRAM_write`; `drop_count`=1; no interrupt. Repeat 300 times → `drop_count` saturates at 255.
- len=5, `rx_abort` after 2 bytes (B0 B1) → writes 0x05B0, 0xB100, 0x0000; `frame_err`=1; one interrupt pulse.
- Hold `SRAM_full`=1 for 10 cycles in WRITE, insert `SRAM_hint` delays of 0 to 5 cycles, and pulse `rx_start` while busy → data stays stable while `SRAM_write` is high, the stray start is ignored, and the frame content is correct.
- Assert `reset_n` low mid-WAIT_HINT → all outputs reach their reset values asynchronously, then a new len=1 frame B7 writes 0x01B7.
